// File: rtl/sys_systemsolaire_timer_bridge32_pkg.sv
// Shared definitions for the 32-bit CPU to 16-bit timer bridge:
// timer/bridge register offsets, FSM states and access classification.
`default_nettype none

package sys_systemsolaire_timer_bridge32_pkg;

  localparam logic [2:0] TMR_STATUS  = 3'd0;
  localparam logic [2:0] TMR_CONTROL = 3'd1;
  localparam logic [2:0] TMR_PERIODL = 3'd2;
  localparam logic [2:0] TMR_PERIODH = 3'd3;
  localparam logic [2:0] TMR_SNAPL   = 3'd4;
  localparam logic [2:0] TMR_SNAPH   = 3'd5;

  localparam logic [2:0] BW_STATUS  = 3'd0;
  localparam logic [2:0] BW_CONTROL = 3'd1;
  localparam logic [2:0] BW_PERIOD  = 3'd2;
  localparam logic [2:0] BW_SNAP    = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WLO  = 3'd1,
    ST_WHI  = 3'd2,
    ST_SNAP = 3'd3,
    ST_RA   = 3'd4,
    ST_RB   = 3'd5,
    ST_RC   = 3'd6,
    ST_DONE = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    AK_RD16   = 3'd0,
    AK_WR16   = 3'd1,
    AK_RD32   = 3'd2,
    AK_WR32   = 3'd3,
    AK_SNAPRD = 3'd4,
    AK_SNAPWR = 3'd5,
    AK_NOP    = 3'd6
  } access_e;

  function automatic access_e classify(input logic [2:0] addr, input logic is_wr);
    access_e k;
    case (addr)
      BW_STATUS, BW_CONTROL: k = is_wr ? AK_WR16   : AK_RD16;
      BW_PERIOD:             k = is_wr ? AK_WR32   : AK_RD32;
      BW_SNAP:               k = is_wr ? AK_SNAPWR : AK_SNAPRD;
      default:               k = AK_NOP;
    endcase
    return k;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sys_systemsolaire_timer_bridge32.sv
// 32-bit Avalon-MM slave that splits accesses into ordered 16-bit
// transactions towards the interval/timestamp timer.
`default_nettype none

module sys_systemsolaire_timer_bridge32
  import sys_systemsolaire_timer_bridge32_pkg::*;
#(
  parameter int SNAP_ATOMIC = 1,
  parameter int TMR_RD_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        s_waitrequest,
  output logic [2:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [15:0] m_writedata,
  input  logic [15:0] m_readdata
);

  if (TMR_RD_LAT != 1) begin : g_rd_lat_check
    $error("sys_systemsolaire_timer_bridge32: only TMR_RD_LAT=1 is supported");
  end

  state_e      state_q;
  access_e     kind_q;
  logic [15:0] wr_hi_q;
  logic [15:0] lo_q;
  logic [31:0] rdata_q;
  logic [2:0]  m_addr_q;
  logic        m_cs_q;
  logic        m_wr_n_q;
  logic [15:0] m_wd_q;

  logic        req;
  access_e     kind_d;
  logic [2:0]  addr16_d;

  assign req      = s_chipselect & (s_read | s_write);
  // A simultaneous read+write request is serviced as a write.
  assign kind_d   = classify(s_address, s_write);
  assign addr16_d = (s_address == BW_STATUS) ? TMR_STATUS : TMR_CONTROL;

  assign s_waitrequest = req & (state_q != ST_DONE);
  assign s_readdata    = rdata_q;
  assign m_address     = m_addr_q;
  assign m_chipselect  = m_cs_q;
  assign m_write_n     = m_wr_n_q;
  assign m_writedata   = m_wd_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      kind_q   <= AK_NOP;
      wr_hi_q  <= '0;
      lo_q     <= '0;
      rdata_q  <= '0;
      m_addr_q <= '0;
      m_cs_q   <= 1'b0;
      m_wr_n_q <= 1'b1;
      m_wd_q   <= '0;
    end else begin
      m_cs_q   <= 1'b0;
      m_wr_n_q <= 1'b1;
      m_wd_q   <= '0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            kind_q  <= kind_d;
            wr_hi_q <= s_writedata[31:16];
            case (kind_d)
              AK_WR16: begin
                m_addr_q <= addr16_d;
                m_cs_q   <= 1'b1;
                m_wr_n_q <= 1'b0;
                m_wd_q   <= s_writedata[15:0];
                state_q  <= ST_WLO;
              end
              AK_WR32: begin
                m_addr_q <= TMR_PERIODL;
                m_cs_q   <= 1'b1;
                m_wr_n_q <= 1'b0;
                m_wd_q   <= s_writedata[15:0];
                state_q  <= ST_WLO;
              end
              AK_SNAPWR: begin
                m_addr_q <= TMR_SNAPL;
                m_cs_q   <= 1'b1;
                m_wr_n_q <= 1'b0;
                state_q  <= ST_WLO;
              end
              AK_RD16: begin
                m_addr_q <= addr16_d;
                m_cs_q   <= 1'b1;
                state_q  <= ST_RA;
              end
              AK_RD32: begin
                m_addr_q <= TMR_PERIODL;
                m_cs_q   <= 1'b1;
                state_q  <= ST_RA;
              end
              AK_SNAPRD: begin
                // Atomic mode strobes the capture before reading both halves.
                m_addr_q <= TMR_SNAPL;
                m_cs_q   <= 1'b1;
                m_wr_n_q <= (SNAP_ATOMIC == 0);
                state_q  <= (SNAP_ATOMIC != 0) ? ST_SNAP : ST_RA;
              end
              default: begin
                if (!s_write) rdata_q <= '0;
                state_q <= ST_DONE;
              end
            endcase
          end
        end
        ST_WLO: begin
          if (kind_q == AK_WR32) begin
            m_addr_q <= TMR_PERIODH;
            m_cs_q   <= 1'b1;
            m_wr_n_q <= 1'b0;
            m_wd_q   <= wr_hi_q;
            state_q  <= ST_WHI;
          end else begin
            state_q  <= ST_DONE;
          end
        end
        ST_WHI: state_q <= ST_DONE;
        ST_SNAP: begin
          m_addr_q <= TMR_SNAPL;
          m_cs_q   <= 1'b1;
          state_q  <= ST_RA;
        end
        ST_RA: begin
          if (kind_q == AK_RD16) begin
            state_q <= ST_RC;
          end else begin
            m_addr_q <= (kind_q == AK_RD32) ? TMR_PERIODH : TMR_SNAPH;
            m_cs_q   <= 1'b1;
            state_q  <= ST_RB;
          end
        end
        ST_RB: begin
          lo_q    <= m_readdata;
          state_q <= ST_RC;
        end
        ST_RC: begin
          rdata_q <= (kind_q == AK_RD16) ? {16'h0000, m_readdata} : {m_readdata, lo_q};
          state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sys_systemsolaire_timer_bridge32.sv
// Bench for the 32-bit timer bridge with a behavioural 16-bit timer downstream.
`default_nettype none

module tb_sys_systemsolaire_timer_bridge32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  s_address = '0;
  logic        s_chipselect = 1'b0;
  logic        s_read = 1'b0;
  logic        s_write = 1'b0;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic        s_waitrequest;
  logic [2:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [15:0] m_writedata;
  logic [15:0] m_readdata;

  always #5 clk = ~clk;

  sys_systemsolaire_timer_bridge32 dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_address    (s_address),
    .s_chipselect (s_chipselect),
    .s_read       (s_read),
    .s_write      (s_write),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata),
    .s_waitrequest(s_waitrequest),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata)
  );

  // Downstream timer: status {RUN,TO}, control {STOP,START,CONT,ITO}.
  logic [15:0] t_perl = '0, t_perh = '0, t_snapl = '0, t_snaph = '0, t_rd = '0;
  logic        t_to = 1'b0, t_run = 1'b0, t_cont = 1'b0;
  logic [31:0] t_cnt = '0;
  assign m_readdata = t_rd;

  always @(posedge clk) begin
    if (t_run) begin
      if (t_cnt == 32'd0) begin
        t_to  <= 1'b1;
        t_cnt <= {t_perh, t_perl};
        if (!t_cont) t_run <= 1'b0;
      end else begin
        t_cnt <= t_cnt - 32'd1;
      end
    end
    if (m_chipselect && !m_write_n) begin
      case (m_address)
        3'd0: t_to <= 1'b0;
        3'd1: begin
          t_cont <= m_writedata[1];
          if (m_writedata[2]) t_run <= 1'b1;
          if (m_writedata[3]) t_run <= 1'b0;
        end
        3'd2: begin t_perl <= m_writedata; t_run <= 1'b0; t_cnt <= {t_perh, m_writedata}; end
        3'd3: begin t_perh <= m_writedata; t_run <= 1'b0; t_cnt <= {m_writedata, t_perl}; end
        3'd4, 3'd5: begin t_snapl <= t_cnt[15:0]; t_snaph <= t_cnt[31:16]; end
        default: ;
      endcase
    end
    case (m_address)
      3'd0:    t_rd <= {14'd0, t_run, t_to};
      3'd1:    t_rd <= {14'd0, t_cont, 1'b0};
      3'd2:    t_rd <= t_perl;
      3'd3:    t_rd <= t_perh;
      3'd4:    t_rd <= t_snapl;
      3'd5:    t_rd <= t_snaph;
      default: t_rd <= 16'h0000;
    endcase
  end

  // Timer-side event log, cycle index relative to the request cycle c0.
  typedef struct {
    int          cyc;
    logic [2:0]  a;
    logic        wr;
    logic [15:0] d;
  } ev_t;
  ev_t evq[$];
  time t0 = 0;

  always @(negedge clk) begin
    if (m_chipselect) begin
      ev_t e;
      e.cyc = int'(($time - t0) / 10);
      e.a   = m_address;
      e.wr  = ~m_write_n;
      e.d   = m_writedata;
      evq.push_back(e);
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_ev(input string nm, input int idx, input int cyc, input logic [2:0] a,
                        input logic wr, input logic [15:0] d);
    if (idx >= evq.size()) begin
      total++;
      bad++;
      $display("FAIL %s: got no timer access want access at cycle %0d", nm, cyc);
    end else begin
      chk({nm, " cyc"}, evq[idx].cyc, cyc);
      chk({nm, " addr"}, {29'd0, evq[idx].a}, {29'd0, a});
      chk({nm, " wr"}, {31'd0, evq[idx].wr}, {31'd0, wr});
      if (wr) chk({nm, " data"}, {16'd0, evq[idx].d}, {16'd0, d});
    end
  endtask

  // Starts at posedge+1 and returns at posedge+1 just after the DONE cycle.
  task automatic access(input logic wr, input logic both, input logic [2:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output int cyc, output int base);
    base         = evq.size();
    t0           = $time;
    s_chipselect = 1'b1;
    s_address    = a;
    s_writedata  = wd;
    s_write      = wr | both;
    s_read       = ~wr | both;
    cyc          = 0;
    forever begin
      @(negedge clk);
      if (!s_waitrequest) break;
      cyc++;
      if (cyc > 40) break;
    end
    rd = s_readdata;
    @(posedge clk);
    #1;
    s_chipselect = 1'b0;
    s_read       = 1'b0;
    s_write      = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_cyc;
    int          exp_cs;
  } vec_t;
  vec_t vt[12];

  initial begin
    logic [31:0] rd;
    logic [31:0] rd1;
    int          cyc;
    int          base;

    vt[0]  = '{1'b1, 3'd2, 32'h0001_86A0, 32'h0000_0000, 3, 2};
    vt[1]  = '{1'b0, 3'd2, 32'h0,         32'h0001_86A0, 4, 2};
    vt[2]  = '{1'b0, 3'd3, 32'h0,         32'h0001_86A0, 5, 3};
    vt[3]  = '{1'b0, 3'd1, 32'h0,         32'h0000_0000, 3, 1};
    vt[4]  = '{1'b0, 3'd0, 32'h0,         32'h0000_0000, 3, 1};
    vt[5]  = '{1'b0, 3'd6, 32'h0,         32'h0000_0000, 1, 0};
    vt[6]  = '{1'b1, 3'd5, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0};
    vt[7]  = '{1'b1, 3'd3, 32'hDEAD_BEEF, 32'h0000_0000, 2, 1};
    vt[8]  = '{1'b1, 3'd1, 32'h0000_0002, 32'h0000_0000, 2, 1};
    vt[9]  = '{1'b0, 3'd1, 32'h0,         32'h0000_0002, 3, 1};
    vt[10] = '{1'b1, 3'd5, 32'h1234_5678, 32'h0000_0002, 1, 0};
    vt[11] = '{1'b0, 3'd7, 32'h0,         32'h0000_0000, 1, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset readdata", s_readdata, 32'h0);
    chk("reset m_cs", {31'd0, m_chipselect}, 32'd0);
    chk("reset m_write_n", {31'd0, m_write_n}, 32'd1);
    chk("reset m_addr", {29'd0, m_address}, 32'd0);
    chk("reset m_wdata", {16'd0, m_writedata}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      access(vt[i].wr, 1'b0, vt[i].a, vt[i].wd, rd, cyc, base);
      chk($sformatf("v%0d rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("v%0d cycles", i), cyc, vt[i].exp_cyc);
      chk($sformatf("v%0d timer accesses", i), evq.size() - base, vt[i].exp_cs);
    end

    // Period write order: low half at c1, high half at c2.
    access(1'b1, 1'b0, 3'd2, 32'h0001_86A0, rd, cyc, base);
    chk("perwr cycles", cyc, 3);
    chk_ev("perwr lo", base, 1, 3'd2, 1'b1, 16'h86A0);
    chk_ev("perwr hi", base + 1, 2, 3'd3, 1'b1, 16'h0001);

    // Atomic snapshot of a running counter.
    access(1'b1, 1'b0, 3'd1, 32'h6, rd, cyc, base);
    repeat (10) @(posedge clk);
    #1;
    access(1'b0, 1'b0, 3'd3, 32'h0, rd, cyc, base);
    chk("snap cycles", cyc, 5);
    chk("snap accesses", evq.size() - base, 3);
    chk_ev("snap capture", base, 1, 3'd4, 1'b1, 16'h0000);
    chk_ev("snap rd lo", base + 1, 2, 3'd4, 1'b0, 16'h0000);
    chk_ev("snap rd hi", base + 2, 3, 3'd5, 1'b0, 16'h0000);
    chk("snap range", {31'd0, (rd <= 32'h0001_86A0)}, 32'd1);
    chk("snap value", rd, {t_snaph, t_snapl});

    // Period 5, continuous run: TO sets, then is cleared by a status write.
    access(1'b1, 1'b0, 3'd2, 32'h0000_0005, rd, cyc, base);
    access(1'b1, 1'b0, 3'd1, 32'h0000_0006, rd, cyc, base);
    repeat (6) @(posedge clk);
    #1;
    access(1'b0, 1'b0, 3'd0, 32'h0, rd, cyc, base);
    chk("status TO+RUN", rd, 32'h3);
    access(1'b1, 1'b0, 3'd0, 32'h0, rd, cyc, base);
    chk("status write hold", rd, 32'h3);
    access(1'b0, 1'b0, 3'd0, 32'h0, rd, cyc, base);
    chk("status cleared", rd, 32'h2);

    // Reset in c2 of a period write: only the low half reaches the timer.
    base         = evq.size();
    t0           = $time;
    s_chipselect = 1'b1;
    s_write      = 1'b1;
    s_read       = 1'b0;
    s_address    = 3'd2;
    s_writedata  = 32'h2222_1111;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n      = 1'b0;
    s_chipselect = 1'b0;
    s_write      = 1'b0;
    #1;
    chk("abort m_cs", {31'd0, m_chipselect}, 32'd0);
    chk("abort m_write_n", {31'd0, m_write_n}, 32'd1);
    chk("abort waitrequest", {31'd0, s_waitrequest}, 32'd0);
    chk("abort readdata", s_readdata, 32'h0);
    repeat (2) @(negedge clk);
    chk("abort accesses", evq.size() - base, 1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    access(1'b0, 1'b0, 3'd2, 32'h0, rd, cyc, base);
    chk("post-abort cycles", cyc, 4);
    chk("post-abort period", rd, 32'h0000_1111);

    // Back-to-back: second request has read and write both set.
    access(1'b0, 1'b0, 3'd1, 32'h0, rd1, cyc, base);
    chk("b2b rd1", rd1, 32'h2);
    access(1'b1, 1'b1, 3'd1, 32'h0, rd, cyc, base);
    chk("b2b rw cycles", cyc, 2);
    chk("b2b rw hold", rd, 32'h2);
    chk_ev("b2b rw access", base, 1, 3'd1, 1'b1, 16'h0000);
    access(1'b0, 1'b0, 3'd1, 32'h0, rd, cyc, base);
    chk("b2b ctrl after", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
